// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one memory port, with an ack timeout.
// Optional macro MEM_ARBITER_RR_EN: round-robin between data and fetch instead of fixed data priority.
module mem_arbiter #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ifReq,
    input  logic [XLEN-1:0] i_ifAddr,
    output logic            o_ifValid,
    output logic [XLEN-1:0] o_instr,
    input  logic            i_loadReq,
    input  logic            i_storeReq,
    input  logic [XLEN-1:0] i_dataAddr,
    input  logic [XLEN-1:0] i_dataOut,
    output logic            o_memValid,
    output logic [XLEN-1:0] o_dataIn,
    output logic            o_memReq,
    output logic            o_memWe,
    output logic [XLEN-1:0] o_memAddr,
    output logic [XLEN-1:0] o_memWdata,
    input  logic            i_memAck,
    input  logic [XLEN-1:0] i_memRdata,
    output logic            o_busErr,
    output logic [1:0]      dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2} state_t;

    // The counter holds the number of unacked request cycles already elapsed,
    // so the abort fires in the cycle that would bring it to MAX_WAIT.
    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

    state_t          state, state_n;
    logic [15:0]     wait_cnt, wait_n;
    logic            req_n, we_n, if_valid_n, mem_valid_n, bus_err_n;
    logic [XLEN-1:0] addr_n, wdata_n, instr_n, data_in_n;
    logic            data_pend, fetch_pend, pick_data;

    assign data_pend  = i_loadReq | i_storeReq;
    assign fetch_pend = i_ifReq;
    assign dbg_state  = state;

`ifdef MEM_ARBITER_RR_EN
    logic last_data, last_data_n;

    // On a tie, serve whichever side did not win last time.
    assign pick_data = data_pend & (~fetch_pend | ~last_data);

    always_comb begin
        last_data_n = last_data;
        if (state == IDLE && (data_pend || fetch_pend)) last_data_n = pick_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) last_data <= 1'b0;
        else       last_data <= last_data_n;
    end
`else
    assign pick_data = data_pend;
`endif

    always_comb begin
        state_n     = state;
        req_n       = o_memReq;
        we_n        = o_memWe;
        addr_n      = o_memAddr;
        wdata_n     = o_memWdata;
        if_valid_n  = 1'b0;
        mem_valid_n = 1'b0;
        instr_n     = o_instr;
        data_in_n   = o_dataIn;
        bus_err_n   = o_busErr;
        wait_n      = wait_cnt;
        case (state)
            IDLE: begin
                if (data_pend || fetch_pend) begin
                    req_n  = 1'b1;
                    wait_n = '0;
                    if (pick_data) begin
                        state_n = DATA;
                        we_n    = i_storeReq;
                        addr_n  = i_dataAddr;
                        wdata_n = i_storeReq ? i_dataOut : '0;
                    end else begin
                        state_n = FETCH;
                        we_n    = 1'b0;
                        addr_n  = i_ifAddr;
                        wdata_n = '0;
                    end
                end
            end
            FETCH, DATA: begin
                if (i_memAck) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    wdata_n = '0;
                    if (state == FETCH) begin
                        if_valid_n = 1'b1;
                        instr_n    = i_memRdata;
                    end else begin
                        mem_valid_n = 1'b1;
                        data_in_n   = o_memWe ? '0 : i_memRdata;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    // Abort: complete the requester with zero data and flag the bus.
                    state_n   = IDLE;
                    req_n     = 1'b0;
                    we_n      = 1'b0;
                    wdata_n   = '0;
                    bus_err_n = 1'b1;
                    wait_n    = wait_cnt + 16'd1;
                    if (state == FETCH) begin
                        if_valid_n = 1'b1;
                        instr_n    = '0;
                    end else begin
                        mem_valid_n = 1'b1;
                        data_in_n   = '0;
                    end
                end else begin
                    wait_n = wait_cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            o_memReq   <= 1'b0;
            o_memWe    <= 1'b0;
            o_memAddr  <= '0;
            o_memWdata <= '0;
            o_ifValid  <= 1'b0;
            o_memValid <= 1'b0;
            o_instr    <= '0;
            o_dataIn   <= '0;
            o_busErr   <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state      <= state_n;
            o_memReq   <= req_n;
            o_memWe    <= we_n;
            o_memAddr  <= addr_n;
            o_memWdata <= wdata_n;
            o_ifValid  <= if_valid_n;
            o_memValid <= mem_valid_n;
            o_instr    <= instr_n;
            o_dataIn   <= data_in_n;
            o_busErr   <= bus_err_n;
            wait_cnt   <= wait_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory responder, grant/result scoreboard, timeout and reset cases.
module tb_mem_arbiter;
    localparam int W = 32;

    typedef struct packed {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         if_req, load_req, store_req;
    logic [W-1:0] if_addr, data_addr, data_out;
    logic         if_valid, mem_valid, mem_req, mem_we, bus_err;
    logic [W-1:0] instr, data_in, mem_addr, mem_wdata, mem_rdata;
    logic         resp_ack, man_ack, mem_ack;
    logic [1:0]   dbg_state;

    int   checks = 0;
    int   errors = 0;
    int   ack_delay = 0;
    txn_t exp_txn_q[$];
    logic [W-1:0] exp_if_q[$];
    logic [W-1:0] exp_mem_q[$];

    assign mem_ack = resp_ack | man_ack;

    mem_arbiter #(.XLEN(W), .MAX_WAIT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ifReq(if_req), .i_ifAddr(if_addr), .o_ifValid(if_valid), .o_instr(instr),
        .i_loadReq(load_req), .i_storeReq(store_req), .i_dataAddr(data_addr),
        .i_dataOut(data_out), .o_memValid(mem_valid), .o_dataIn(data_in),
        .o_memReq(mem_req), .o_memWe(mem_we), .o_memAddr(mem_addr), .o_memWdata(mem_wdata),
        .i_memAck(mem_ack), .i_memRdata(mem_rdata), .o_busErr(bus_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] rd_model(input logic [W-1:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : ((a ^ 32'hC0DE_0000) + 32'd7);
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_txn(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata);
        txn_t t;
        t.we = we;
        t.addr = addr;
        t.wdata = wdata;
        exp_txn_q.push_back(t);
    endtask

    // Waits for the completion pulse, counting elapsed cycles and request cycles, then drops the request.
    task automatic wait_valid(input bit fetch, input int budget, output int cyc, output int rc);
        bit seen;
        cyc = 0;
        rc = 0;
        seen = 1'b0;
        while (!seen && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_req) rc++;
            seen = fetch ? if_valid : mem_valid;
        end
        check(fetch ? "if_valid_seen" : "mem_valid_seen", 32'(seen), 32'd1);
        if (fetch) if_req = 1'b0;
        else begin
            load_req = 1'b0;
            store_req = 1'b0;
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin : responder
        int cnt;
        cnt = 0;
        resp_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_req) begin
                resp_ack = 1'b0;
                cnt = 0;
            end else if (ack_delay >= 0 && cnt == ack_delay) begin
                resp_ack = 1'b1;
                mem_rdata = rd_model(mem_addr);
                cnt++;
            end else begin
                resp_ack = 1'b0;
                cnt++;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        txn_t t, hold;
        logic prev_req;
        logic [W-1:0] e;
        prev_req = 1'b0;
        hold = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_req && !prev_req) begin
                    check("txn_expected", 32'(exp_txn_q.size() != 0), 32'd1);
                    if (exp_txn_q.size() != 0) begin
                        t = exp_txn_q.pop_front();
                        check("grant_addr", mem_addr, t.addr);
                        check("grant_we", 32'(mem_we), 32'(t.we));
                        check("grant_wdata", mem_wdata, t.wdata);
                        hold = t;
                    end
                end else if (mem_req) begin
                    check("hold_addr", mem_addr, hold.addr);
                    check("hold_we", 32'(mem_we), 32'(hold.we));
                    check("hold_wdata", mem_wdata, hold.wdata);
                end
                if (if_valid) begin
                    check("if_valid_expected", 32'(exp_if_q.size() != 0), 32'd1);
                    if (exp_if_q.size() != 0) begin
                        e = exp_if_q.pop_front();
                        check("instr", instr, e);
                    end
                end
                if (mem_valid) begin
                    check("mem_valid_expected", 32'(exp_mem_q.size() != 0), 32'd1);
                    if (exp_mem_q.size() != 0) begin
                        e = exp_mem_q.pop_front();
                        check("data_in", data_in, e);
                    end
                end
            end
            prev_req = mem_req && !rst;
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin : stimulus
        int cyc, rc, done;
        logic [W-1:0] held;
        rst = 1'b1;
        if_req = 1'b0;
        load_req = 1'b0;
        store_req = 1'b0;
        if_addr = '0;
        data_addr = '0;
        data_out = '0;
        man_ack = 1'b0;

        // Reset state
        step(2);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_data_in", data_in, 32'd0);
        rst = 1'b0;
        step(1);

        // Single fetch, ack in the first request cycle
        ack_delay = 0;
        push_txn(1'b0, 32'h100, 32'h0);
        exp_if_q.push_back(rd_model(32'h100));
        if_addr = 32'h100;
        if_req = 1'b1;
        wait_valid(1'b1, 10, cyc, rc);
        check("fetch_latency", cyc, 32'd2);
        check("fetch_req_cycles", rc, 32'd1);
        check("fetch_req_dropped", 32'(mem_req), 32'd0);
        check("fetch_instr_now", instr, 32'h0000_0013);
        step(1);
        check("fetch_pulse_one_cycle", 32'(if_valid), 32'd0);

        // Store, ack on third request cycle
        ack_delay = 2;
        push_txn(1'b1, 32'h3000, 32'hDEAD_BEEF);
        exp_mem_q.push_back(32'h0);
        data_addr = 32'h3000;
        data_out = 32'hDEAD_BEEF;
        store_req = 1'b1;
        wait_valid(1'b0, 10, cyc, rc);
        check("store_latency", cyc, 32'd4);

        // Load and fetch together: data wins, then fetch back-to-back
        ack_delay = 3;
        push_txn(1'b0, 32'h2000, 32'h0);
        push_txn(1'b0, 32'h104, 32'h0);
        exp_mem_q.push_back(rd_model(32'h2000));
        exp_if_q.push_back(rd_model(32'h104));
        data_addr = 32'h2000;
        data_out = 32'hFFFF_FFFF;
        if_addr = 32'h104;
        load_req = 1'b1;
        if_req = 1'b1;
        wait_valid(1'b0, 12, cyc, rc);
        check("load_latency", cyc, 32'd5);
        check("load_req_cycles", rc, 32'd4);
        wait_valid(1'b1, 12, cyc, rc);
        check("b2b_fetch_latency", cyc, 32'd5);
        check("data_in_holds", data_in, rd_model(32'h2000));

        // Simultaneous load and store resolve to a store
        ack_delay = 0;
        push_txn(1'b1, 32'h3004, 32'h1234_5678);
        exp_mem_q.push_back(32'h0);
        data_addr = 32'h3004;
        data_out = 32'h1234_5678;
        load_req = 1'b1;
        store_req = 1'b1;
        wait_valid(1'b0, 10, cyc, rc);
        check("ldst_latency", cyc, 32'd2);

        // Ack while idle is ignored
        step(1);
        man_ack = 1'b1;
        step(1);
        man_ack = 1'b0;
        step(2);
        check("idle_ack_state", 32'(dbg_state), 32'd0);
        check("idle_ack_req", 32'(mem_req), 32'd0);

        // Requester withdraws mid-transaction; completion still issued
        ack_delay = 2;
        push_txn(1'b0, 32'h180, 32'h0);
        exp_if_q.push_back(rd_model(32'h180));
        if_addr = 32'h180;
        if_req = 1'b1;
        step(2);
        if_req = 1'b0;
        wait_valid(1'b1, 10, cyc, rc);
        check("withdraw_remaining", cyc, 32'd2);

        // Timeout with MAX_WAIT=4
        ack_delay = -1;
        push_txn(1'b0, 32'h4000, 32'h0);
        exp_mem_q.push_back(32'h0);
        data_addr = 32'h4000;
        load_req = 1'b1;
        wait_valid(1'b0, 20, cyc, rc);
        check("timeout_req_cycles", rc, 32'd4);
        check("timeout_latency", cyc, 32'd5);
        check("timeout_bus_err", 32'(bus_err), 32'd1);
        check("timeout_data_zero", data_in, 32'd0);

        // Bus error stays set across a good transaction
        ack_delay = 1;
        push_txn(1'b0, 32'h108, 32'h0);
        exp_if_q.push_back(rd_model(32'h108));
        if_addr = 32'h108;
        if_req = 1'b1;
        wait_valid(1'b1, 10, cyc, rc);
        step(2);
        check("bus_err_sticky", 32'(bus_err), 32'd1);
        held = rd_model(32'h108);
        check("instr_holds", instr, held);

        // Reset during a data wait, ack arrives afterwards
        ack_delay = -1;
        push_txn(1'b0, 32'h5000, 32'h0);
        data_addr = 32'h5000;
        load_req = 1'b1;
        step(2);
        check("pre_rst_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        load_req = 1'b0;
        step(1);
        rst = 1'b0;
        man_ack = 1'b1;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'd0);
        check("rst_mid_bus_err", 32'(bus_err), 32'd0);
        check("rst_mid_instr", instr, 32'd0);
        step(1);
        man_ack = 1'b0;
        check("late_ack_no_valid", 32'(mem_valid), 32'd0);
        check("late_ack_state", 32'(dbg_state), 32'd0);
        step(1);
        check("late_ack_no_req", 32'(mem_req), 32'd0);

        // Both requesters continuously pending
        ack_delay = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_RR_EN
            if (k % 2 == 0) begin
`else
            if (1'b1) begin
`endif
                push_txn(1'b0, 32'h6000, 32'h0);
                exp_mem_q.push_back(rd_model(32'h6000));
            end else begin
                push_txn(1'b0, 32'h6100, 32'h0);
                exp_if_q.push_back(rd_model(32'h6100));
            end
        end
        data_addr = 32'h6000;
        if_addr = 32'h6100;
        load_req = 1'b1;
        if_req = 1'b1;
        done = 0;
        cyc = 0;
        while (done < 4 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (if_valid || mem_valid) done++;
        end
        load_req = 1'b0;
        if_req = 1'b0;
        check("contend_done", done, 32'd4);
        check("contend_cycles", cyc, 32'd8);
        step(3);

        check("txn_q_drained", 32'(exp_txn_q.size()), 32'd0);
        check("if_q_drained", 32'(exp_if_q.size()), 32'd0);
        check("mem_q_drained", 32'(exp_mem_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
